// File: rtl/cmp_pkg.sv
// Shared types and helpers for the limb-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } res_t;

    // A single-limb operand still needs a 1-bit counter.
    function automatic int cnt_width(input int limbs);
        return (limbs <= 1) ? 1 : $clog2(limbs);
    endfunction

endpackage

// File: rtl/limb_serial_comparator_if.sv
// Command, limb stream and result bundle of the limb-serial comparator.
interface limb_serial_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_limb;
    logic [WIDTH-1:0] b_limb;
    logic             busy;
    logic             res_valid;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, signed_mode, in_valid, a_limb, b_limb,
        input  in_ready, busy, res_valid, eq, gt, lt
    );

    modport slave (
        input  start, signed_mode, in_valid, a_limb, b_limb,
        output in_ready, busy, res_valid, eq, gt, lt
    );
endinterface

// File: rtl/limb_cmp.sv
// Combinational eq/gt of one limb pair, built as an LSB-to-MSB ripple of bit cells.
module limb_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             limb_eq,
    output logic             limb_gt
);
    logic [WIDTH:0] eq_chain;
    logic [WIDTH:0] gt_chain;

    assign eq_chain[0] = 1'b1;
    assign gt_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_gt;
            if (gi == WIDTH - 1) begin : g_msb
                // In two's complement a set sign bit means smaller.
                assign bit_gt = is_signed ? (~a[gi] & b[gi]) : (a[gi] & ~b[gi]);
            end else begin : g_lsb
                assign bit_gt = a[gi] & ~b[gi];
            end
            assign eq_chain[gi+1] = eq_chain[gi] & ~(a[gi] ^ b[gi]);
            assign gt_chain[gi+1] = bit_gt | (~(a[gi] ^ b[gi]) & gt_chain[gi]);
        end
    endgenerate

    assign limb_eq = eq_chain[WIDTH];
    assign limb_gt = gt_chain[WIDTH];
endmodule

// File: rtl/limb_serial_comparator.sv
// Compares two LIMBS*WIDTH-bit operands streamed MSB limb first; first unequal limb decides.
module limb_serial_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMBS = 4
) (
    input logic                    clk,
    input logic                    rst,
    limb_serial_comparator_if.slave bus
);
    localparam int            CW      = cnt_width(LIMBS);
    localparam logic [CW-1:0] CNT_TOP = CW'(LIMBS - 1);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            decided_reg;
    logic            signed_reg;
    res_t            res_lat_reg;
    logic            in_ready_reg;
    logic            busy_reg;
    logic            res_valid_reg;
    logic            eq_reg;
    logic            gt_reg;
    logic            lt_reg;

    logic            first_limb;
    logic            beat;
    logic            limb_eq;
    logic            limb_gt;
    logic            dec_now;
    logic            gt_now;

    assign first_limb = (cnt_reg == CNT_TOP);
    assign beat       = bus.in_valid & in_ready_reg;

    limb_cmp #(.WIDTH(WIDTH)) u_limb_cmp (
        .a         (bus.a_limb),
        .b         (bus.b_limb),
        .is_signed (signed_reg & first_limb),
        .limb_eq   (limb_eq),
        .limb_gt   (limb_gt)
    );

    // Decision including the beat being accepted, so the last limb can decide too.
    assign dec_now = decided_reg | ~limb_eq;
    assign gt_now  = decided_reg ? (res_lat_reg == RES_GT) : limb_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            decided_reg   <= 1'b0;
            signed_reg    <= 1'b0;
            res_lat_reg   <= RES_EQ;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            eq_reg        <= 1'b0;
            gt_reg        <= 1'b0;
            lt_reg        <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_reg    <= ST_RUN;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        eq_reg       <= 1'b0;
                        gt_reg       <= 1'b0;
                        lt_reg       <= 1'b0;
                        decided_reg  <= 1'b0;
                        res_lat_reg  <= RES_EQ;
                        cnt_reg      <= CNT_TOP;
                        signed_reg   <= bus.signed_mode;
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        if (!decided_reg && !limb_eq) begin
                            decided_reg <= 1'b1;
                            res_lat_reg <= limb_gt ? RES_GT : RES_LT;
                        end
                        if (cnt_reg == '0) begin
                            state_reg     <= ST_DONE;
                            in_ready_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            res_valid_reg <= 1'b1;
                            eq_reg        <= ~dec_now;
                            gt_reg        <= dec_now & gt_now;
                            lt_reg        <= dec_now & ~gt_now;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.eq        = eq_reg;
    assign bus.gt        = gt_reg;
    assign bus.lt        = lt_reg;
endmodule

// File: tb/tb_limb_serial_comparator.sv
// Directed bench for limb_serial_comparator (WIDTH=8, LIMBS=4), one line per transaction.
module tb_limb_serial_comparator;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    limb_serial_comparator_if #(.WIDTH(8)) bus ();

    limb_serial_comparator #(.WIDTH(8), .LIMBS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns at cycle 1 relative to the accepted start.
    task automatic do_start(input logic sm);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        tick();
        bus.start = 1'b0;
    endtask

    // Stream one comparison; optional stall of stall_len cycles before limb index stall_at.
    task automatic run_cmp(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sm, input int stall_at, input int stall_len,
                           input logic [2:0] exp_egl);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        do_start(sm);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.in_valid = 1'b0;
                    bus.start    = (s == 0);
                    tick();
                    bus.start = 1'b0;
                    check({name, "_stall_busy"}, {31'd0, bus.busy}, 32'd1);
                    check({name, "_stall_rv"}, {31'd0, bus.res_valid}, 32'd0);
                end
            end
            bus.in_valid = 1'b1;
            bus.a_limb   = av[8*(3-i) +: 8];
            bus.b_limb   = bv[8*(3-i) +: 8];
            check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
            check({name, "_run_egl"}, {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
            check({name, "_run_rv"}, {31'd0, bus.res_valid}, 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check({name, "_res_valid"}, {31'd0, bus.res_valid}, 32'd1);
        check({name, "_egl"}, {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, exp_egl});
        check({name, "_busy_done"}, {30'd0, bus.busy, bus.in_ready}, 32'd0);
        tick();
        check({name, "_rv_pulse"}, {31'd0, bus.res_valid}, 32'd0);
        check({name, "_egl_held"}, {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, exp_egl});
        $display("txn %s A=%08h B=%08h signed=%0d stall=%0d egl=%03b", name, a, b, sm,
                 stall_len, {bus.eq, bus.gt, bus.lt});
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a_limb      = '0;
        bus.b_limb      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outs", {26'd0, bus.in_ready, bus.busy, bus.res_valid, bus.eq, bus.gt, bus.lt}, 32'd0);

        bus.in_valid = 1'b1;
        tick();
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        bus.in_valid = 1'b0;
        $display("txn idle in_valid ignored");

        run_cmp("s1_gt",       32'h12345678, 32'h12345677, 1'b0, -1, 0, 3'b010);
        run_cmp("s2_eq",       32'hDEADBEEF, 32'hDEADBEEF, 1'b0, -1, 0, 3'b100);
        run_cmp("s3_early",    32'h01FFFFFF, 32'h02000000, 1'b0, -1, 0, 3'b001);
        run_cmp("s4_signed",   32'h80000000, 32'h00000001, 1'b1, -1, 0, 3'b001);
        run_cmp("s4_unsigned", 32'h80000000, 32'h00000001, 1'b0, -1, 0, 3'b010);
        run_cmp("s4_lowlimb",  32'h00FF0000, 32'h007F0000, 1'b1, -1, 0, 3'b010);
        run_cmp("s5_stall",    32'h12345678, 32'h12345677, 1'b0,  2, 2, 3'b010);

        // Reset after two accepted limbs.
        do_start(1'b0);
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.a_limb   = 8'hAA;
            bus.b_limb   = 8'h55;
            tick();
        end
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("s6_reset_outs", {26'd0, bus.in_ready, bus.busy, bus.res_valid, bus.eq, bus.gt, bus.lt}, 32'd0);
        $display("txn s6 reset mid-run");
        run_cmp("s6_fresh", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, -1, 0, 3'b100);

        // Start coinciding with res_valid restarts on the next cycle.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a_limb   = 8'h10;
            bus.b_limb   = 8'h20;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        check("s7_rv_with_start", {31'd0, bus.res_valid}, 32'd1);
        check("s7_egl", {29'd0, bus.eq, bus.gt, bus.lt}, 32'b001);
        tick();
        bus.start = 1'b0;
        check("s7_restart_busy", {30'd0, bus.busy, bus.in_ready}, 32'b11);
        check("s7_restart_clear", {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
        $display("txn s7 start on res_valid");
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a_limb   = 8'h00;
            bus.b_limb   = 8'h00;
            tick();
        end
        bus.in_valid = 1'b0;
        check("s7_second_rv", {31'd0, bus.res_valid}, 32'd1);
        check("s7_second_egl", {29'd0, bus.eq, bus.gt, bus.lt}, 32'b100);
        $display("txn s7 second run eq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
